// File: rtl/chunked_seq_adder.sv
// Multi-cycle ripple-carry adder/subtractor: adds CHUNK bits per clock with a registered
// carry between chunks, behind a start/busy/done handshake.
module chunked_seq_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Co,
   output logic             Ov
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
      $error("chunked_seq_adder: CHUNK must divide WIDTH");
   end

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             co_q, co_d;
   logic             ov_q, ov_d;

   logic [CHUNK:0]   add_s;
   logic [WIDTH-1:0] res_next_s;
   logic             last_s;
   logic             msb_cin_s;

   // Chunk adder: operands are shifted right each cycle so the live chunk is always the low bits.
   always_comb begin
      add_s      = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
      res_next_s = (res_q >> CHUNK) | (WIDTH'(add_s[CHUNK-1:0]) << (WIDTH - CHUNK));
      last_s     = (cnt_q == CW'(NCHUNK - 1));
      // On the last chunk the low bits hold the original MSBs, so this recovers carry-into-MSB.
      msb_cin_s  = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ add_s[CHUNK-1];
   end

   // Next-state and output computation for the IDLE/RUN sequencer.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      s_d     = s_q;
      co_d    = co_q;
      ov_d    = ov_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = B ^ {WIDTH{sub}};
               carry_d = sub;
               cnt_d   = '0;
               res_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_d     = a_q >> CHUNK;
            b_d     = b_q >> CHUNK;
            res_d   = res_next_s;
            carry_d = add_s[CHUNK];
            if (last_s) begin
               cnt_d   = '0;
               s_d     = res_next_s;
               co_d    = add_s[CHUNK];
               ov_d    = msb_cin_s ^ add_s[CHUNK];
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d   = cnt_q + CW'(1);
               state_d = RUN;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         s_q     <= '0;
         co_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         s_q     <= s_d;
         co_q    <= co_d;
         ov_q    <= ov_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign S    = s_q;
   assign Co   = co_q;
   assign Ov   = ov_q;

endmodule
